// File: rtl/brent_wide_add_ctrl.sv
// brent_wide_add_ctrl: multi-word add/subtract sequencer around one shared
// 32-bit Brent-Kung adder. One word per cycle, LS word first, carry kept in
// a register between words.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             request a new operation (sampled only while idle)
//   sub               0: A+B+cin, 1: A-B (cin ignored)
//   cin               carry-in for addition
//   a_in, b_in        W-bit operands, W = 32*WORDS
//   busy              operation in progress
//   done              one-cycle pulse when results are valid
//   sum_out           W-bit result
//   cout              carry out of top word (sub: 1 = no borrow)
//   overflow          two's-complement overflow of the full W-bit result

// brent32: 32-bit Brent-Kung prefix adder (combinational).
//   a_i, b_i, cin_i -> sum_o, cout_o
module brent32 (
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        cin_i,
   output logic [31:0] sum_o,
   output logic        cout_o
);

   always_comb begin
      logic [31:0] g;
      logic [31:0] p;
      logic [31:0] gg;
      logic [31:0] pp;
      g  = a_i & b_i;
      p  = a_i ^ b_i;
      pp = p;
      gg = g;
      // Fold carry-in into bit 0 so gg[i] becomes the carry out of bit i.
      gg[0] = g[0] | (p[0] & cin_i);
      // Up-sweep: build group (G,P) over power-of-two spans.
      for (int l = 0; l < 5; l++) begin
         for (int i = (1 << (l + 1)) - 1; i < 32; i += (1 << (l + 1))) begin
            gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
            pp[i] = pp[i] & pp[i - (1 << l)];
         end
      end
      // Down-sweep: fill in the remaining prefixes.
      for (int l = 3; l >= 0; l--) begin
         for (int i = 3 * (1 << l) - 1; i < 32; i += (1 << (l + 1))) begin
            gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
            pp[i] = pp[i] & pp[i - (1 << l)];
         end
      end
      sum_o  = p ^ {gg[30:0], cin_i};
      cout_o = gg[31];
   end

endmodule

module brent_wide_add_ctrl #(
   parameter int unsigned WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  sub,
   input  logic                  cin,
   input  logic [32*WORDS-1:0]   a_in,
   input  logic [32*WORDS-1:0]   b_in,
   output logic                  busy,
   output logic                  done,
   output logic [32*WORDS-1:0]   sum_out,
   output logic                  cout,
   output logic                  overflow
);

   localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

   state_e                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q;
   logic                    c_q;
   logic [WORDS-1:0][31:0]  a_q;
   logic [WORDS-1:0][31:0]  b_q;
   logic [WORDS-1:0][31:0]  sum_q;
   logic                    cout_q;
   logic                    ovf_q;
   logic                    done_q;

   logic                    load_c;
   logic                    step_c;
   logic                    last_c;

   logic [31:0]             add_sum;
   logic                    add_cout;

   // Shared word adder.
   brent32 u_add (
      .a_i    (a_q[idx_q]),
      .b_i    (b_q[idx_q]),
      .cin_i  (c_q),
      .sum_o  (add_sum),
      .cout_o (add_cout)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (idx_q == LAST_IDX) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Control decode.
   always_comb begin
      load_c = 1'b0;
      step_c = 1'b0;
      last_c = 1'b0;
      case (state_q)
         IDLE: load_c = start;
         RUN: begin
            step_c = 1'b1;
            last_c = (idx_q == LAST_IDX);
         end
         default: ;
      endcase
   end

   // Operand, carry, word counter and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q  <= '0;
         c_q    <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         sum_q  <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (load_c) begin
            a_q   <= a_in;
            // Subtraction as A + ~B + 1.
            b_q   <= sub ? ~b_in : b_in;
            c_q   <= sub ? 1'b1 : cin;
            idx_q <= '0;
         end
         if (step_c) begin
            sum_q[idx_q] <= add_sum;
            c_q          <= add_cout;
            if (!last_c) begin
               idx_q <= idx_q + IDX_W'(1);
            end else begin
               cout_q <= add_cout;
               // Top word is being processed, so its MSBs are the W-bit MSBs.
               ovf_q  <= (a_q[idx_q][31] == b_q[idx_q][31]) &&
                         (add_sum[31] != a_q[idx_q][31]);
               done_q <= 1'b1;
            end
         end
      end
   end

   assign busy     = (state_q == RUN);
   assign done     = done_q;
   assign sum_out  = sum_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_brent_wide_add_ctrl.sv
// Testbench for brent_wide_add_ctrl (WORDS=4), random + directed scenarios
// checked against a wide-integer reference model.
module tb_brent_wide_add_ctrl;

   localparam int unsigned WORDS = 4;
   localparam int unsigned W     = 32 * WORDS;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         sub;
   logic         cin;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic         busy;
   logic         done;
   logic [W-1:0] sum_out;
   logic         cout;
   logic         overflow;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   brent_wide_add_ctrl #(.WORDS(WORDS)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .sub      (sub),
      .cin      (cin),
      .a_in     (a_in),
      .b_in     (b_in),
      .busy     (busy),
      .done     (done),
      .sum_out  (sum_out),
      .cout     (cout),
      .overflow (overflow)
   );

   // Reference: plain wide integer arithmetic, signed range check for overflow.
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic c,
                        output logic [W-1:0] sum, output logic co,
                        output logic ov);
      logic [W+1:0] ua, ub, ur;
      logic signed [W+1:0] sa, sb, sr;
      ua = {2'b00, a};
      ub = {2'b00, b};
      sa = {{2{a[W-1]}}, a};
      sb = {{2{b[W-1]}}, b};
      if (s) begin
         ur = ua - ub;
         co = (a >= b);
         sr = sa - sb;
      end else begin
         ur = ua + ub + (W+2)'(c);
         co = ur[W];
         sr = sa + sb + (W+2)'(c);
      end
      sum = ur[W-1:0];
      ov  = (sr[W] != sr[W-1]);
   endtask

   // Drives one start from an idle cycle and waits (bounded) for done.
   // lat counts cycles from the start cycle to the done cycle.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic c,
                        output int lat, output int busy_cnt);
      start = 1'b1; sub = s; cin = c; a_in = a; b_in = b;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      busy_cnt = 0;
      while (!done && lat < 20) begin
         if (busy) busy_cnt++;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic check_result(input string name, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic s,
                               input logic c);
      logic [W-1:0] es; logic ec, eo;
      model(a, b, s, c, es, ec, eo);
      tests_run++;
      if (sum_out !== es || cout !== ec || overflow !== eo) begin
         tests_failed++;
         $display("FAIL %s: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                  name, sum_out, cout, overflow, es, ec, eo);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a_in = '0; b_in = '0;
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if ({busy, done, cout, overflow} !== 4'b0 || sum_out !== '0) begin
         tests_failed++;
         $display("FAIL reset: got busy=%b done=%b cout=%b ovf=%b sum=%h, want all 0",
                  busy, done, cout, overflow, sum_out);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_directed;
      int lat, bc;
      logic [W-1:0] a, b;
      // all ones + 1
      a = '1; b = W'(1);
      do_op(a, b, 1'b0, 1'b0, lat, bc);
      tests_run++;
      if (lat !== 5 || bc !== 4) begin
         tests_failed++;
         $display("FAIL latency: got lat=%0d busy_cycles=%0d, want 5 and 4", lat, bc);
      end
      check_result("add_all_ones", a, b, 1'b0, 1'b0);
      tests_run++;
      if (sum_out !== '0 || cout !== 1'b1) begin
         tests_failed++;
         $display("FAIL add_all_ones_const: got sum=%h cout=%b, want 0 and 1", sum_out, cout);
      end
      @(posedge clk); #1;
      tests_run++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL done_pulse: got done=%b busy=%b one cycle later, want 0 0", done, busy);
      end
      // signed overflow
      a = {1'b0, {(W-1){1'b1}}}; b = W'(1);
      do_op(a, b, 1'b0, 1'b0, lat, bc);
      check_result("add_signed_ovf", a, b, 1'b0, 1'b0);
      tests_run++;
      if (sum_out !== {1'b1, {(W-1){1'b0}}} || overflow !== 1'b1 || cout !== 1'b0) begin
         tests_failed++;
         $display("FAIL add_signed_ovf_const: got sum=%h ovf=%b cout=%b", sum_out, overflow, cout);
      end
      @(posedge clk); #1;
      // subtract with borrow
      a = '0; b = W'(1);
      do_op(a, b, 1'b1, 1'b1, lat, bc);
      check_result("sub_borrow", a, b, 1'b1, 1'b1);
      tests_run++;
      if (sum_out !== '1 || cout !== 1'b0 || overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL sub_borrow_const: got sum=%h cout=%b ovf=%b", sum_out, cout, overflow);
      end
      @(posedge clk); #1;
      // subtract to zero
      a = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321; b = a;
      do_op(a, b, 1'b1, 1'b0, lat, bc);
      check_result("sub_zero", a, b, 1'b1, 1'b0);
      @(posedge clk); #1;
      // carry across words
      a = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF}; b = W'(1);
      do_op(a, b, 1'b0, 1'b0, lat, bc);
      tests_run++;
      if (sum_out !== 128'h0000_0000_0000_0001_0000_0000_0000_0000) begin
         tests_failed++;
         $display("FAIL carry_words: got sum=%h, want 2^64", sum_out);
      end
      @(posedge clk); #1;
      // carry-in only
      do_op('0, '0, 1'b0, 1'b1, lat, bc);
      tests_run++;
      if (sum_out !== W'(1) || cout !== 1'b0) begin
         tests_failed++;
         $display("FAIL cin_only: got sum=%h cout=%b, want 1 and 0", sum_out, cout);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random;
      int lat, bc;
      logic [W-1:0] a, b;
      logic s, c;
      for (int n = 0; n < 40; n++) begin
         for (int k = 0; k < WORDS; k++) begin
            a[32*k +: 32] = $urandom;
            b[32*k +: 32] = $urandom;
         end
         // Occasionally force word-boundary carry chains.
         if (n % 5 == 0) a[95:0] = '1;
         if (n % 7 == 0) b = a;
         s = 1'($urandom_range(0, 1));
         c = 1'($urandom_range(0, 1));
         do_op(a, b, s, c, lat, bc);
         tests_run++;
         if (lat !== 5) begin
            tests_failed++;
            $display("FAIL random_latency[%0d]: got %0d, want 5", n, lat);
         end
         check_result("random", a, b, s, c);
         if ((n % 3) == 0) begin
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_ignored_start;
      int lat;
      logic [W-1:0] a, b;
      a = 128'hDEAD_BEEF_0000_0001_FFFF_FFFF_8000_0000;
      b = 128'h0000_0001_1111_1111_0000_0001_8000_0000;
      start = 1'b1; sub = 1'b0; cin = 1'b1; a_in = a; b_in = b;
      @(posedge clk); #1;
      lat = 1;
      for (int i = 0; i < 3; i++) begin
         start = 1'b1; sub = 1'b1; cin = 1'b0; a_in = ~a; b_in = a;
         @(posedge clk); #1;
         lat++;
      end
      start = 1'b0;
      while (!done && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      tests_run++;
      if (lat !== 5) begin
         tests_failed++;
         $display("FAIL ignored_start_latency: got %0d, want 5", lat);
      end
      check_result("ignored_start", a, b, 1'b0, 1'b1);
      @(posedge clk); #1;
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL ignored_start_idle: got busy=%b, want 0", busy);
      end
   endtask

   task automatic test_back_to_back;
      int lat, bc;
      logic [W-1:0] a1, b1, a2, b2;
      a1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      b1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
      a2 = 128'h8000_0000_0000_0000_0000_0000_0000_0000;
      b2 = 128'h0000_0000_0000_0000_0000_0000_0000_0001;
      do_op(a1, b1, 1'b0, 1'b0, lat, bc);
      check_result("b2b_first", a1, b1, 1'b0, 1'b0);
      // Still in the done cycle: issue the next start now.
      do_op(a2, b2, 1'b1, 1'b0, lat, bc);
      tests_run++;
      if (lat !== 5 || bc !== 4) begin
         tests_failed++;
         $display("FAIL b2b_latency: got lat=%0d busy_cycles=%0d, want 5 and 4", lat, bc);
      end
      check_result("b2b_second", a2, b2, 1'b1, 1'b0);
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid;
      int done_seen;
      start = 1'b1; sub = 1'b0; cin = 1'b0; a_in = '1; b_in = '1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      tests_run++;
      if (busy !== 1'b0 || sum_out !== '0 || done !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_mid: got busy=%b done=%b sum=%h, want 0 0 0",
                  busy, done, sum_out);
      end
      done_seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (done) done_seen++;
         if (busy) done_seen++;
         @(posedge clk); #1;
      end
      tests_run++;
      if (done_seen !== 0) begin
         tests_failed++;
         $display("FAIL reset_mid_no_done: got %0d done/busy cycles, want 0", done_seen);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_ignored_start();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
